// File: rtl/avalon_frame_regs.sv
// avalon_frame_regs
// -----------------
// Avalon-MM slave register bank that feeds the GravSim fabric. Software fills
// a shadow bank of NUM_CH channel words, then writes CTRL.commit to copy the
// whole shadow bank into the live bank in a single clock edge. The live bank
// is exported flat toward the physics/render pipeline together with a
// frame-pending handshake (EXPORT_NEW / EXPORT_ACK).
//
// Word address map:
//   0 .. NUM_CH-1 : shadow channel k (R/W, byte-enabled writes)
//   NUM_CH        : CTRL   (W only, reads 0)
//                   bit0 commit, bit1 clear overrun,
//                   bit2 irq enable, bit3 clear irq flag (IRQ build only)
//   NUM_CH+1      : STATUS (RO) bit0 pending, bit1 overrun,
//                   bit2 irq flag (IRQ build only), bits[31:16] frame count
//   others        : read 0, writes ignored
//
// Ports:
//   CLK, RESET         clock and synchronous active-high reset
//   AVL_*              Avalon-MM slave, zero write wait states, read latency 1
//   EXPORT_DATA        live bank, channel k at [k*DATA_W +: DATA_W]
//   EXPORT_NEW         frame pending toward the consumer
//   EXPORT_ACK         consumer has taken the frame (sampled every cycle)
//   FRAME_CNT          committed-frame counter, wraps at 16 bits
//   IRQ                frame-consumed interrupt (only with AVL_FRAME_IRQ_EN)
//
// Optional feature macro: AVL_FRAME_IRQ_EN

module avalon_frame_regs #(
  parameter int NUM_CH = 8,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [ADDR_W-1:0]        AVL_ADDR,
  input  logic                     AVL_CS,
  input  logic                     AVL_READ,
  input  logic                     AVL_WRITE,
  input  logic [DATA_W/8-1:0]      AVL_BYTE_EN,
  input  logic [DATA_W-1:0]        AVL_WRITEDATA,
  output logic [DATA_W-1:0]        AVL_READDATA,
  output logic [NUM_CH*DATA_W-1:0] EXPORT_DATA,
  output logic                     EXPORT_NEW,
  input  logic                     EXPORT_ACK,
  output logic [15:0]              FRAME_CNT
`ifdef AVL_FRAME_IRQ_EN
  ,
  output logic                     IRQ
`endif
);

  localparam int NUM_BYTES = DATA_W / 8;
  // STATUS is defined as a 32-bit word; widen to cover DATA_W either way.
  localparam int STAT_W    = (DATA_W > 32) ? DATA_W : 32;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] shadow_reg [NUM_CH];
  logic [DATA_W-1:0] live_reg   [NUM_CH];
  logic [DATA_W-1:0] readdata_reg;
  logic [DATA_W-1:0] readdata_next;
  logic              pending_reg;
  logic              pending_next;
  logic              overrun_reg;
  logic              overrun_next;
  logic [15:0]       frame_cnt_reg;
  logic [15:0]       frame_cnt_next;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [NUM_CH-1:0] ch_sel;
  logic              ctrl_sel;
  logic              status_sel;
  logic              wr_en;
  logic              rd_en;
  logic              ctrl_wr;
  logic              commit;
  logic              clr_overrun;
  logic              consume;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch_sel
      assign ch_sel[gi] = (AVL_ADDR == ADDR_W'(gi));
    end
  endgenerate

  assign ctrl_sel    = (AVL_ADDR == ADDR_W'(NUM_CH));
  assign status_sel  = (AVL_ADDR == ADDR_W'(NUM_CH + 1));
  assign wr_en       = AVL_CS & AVL_WRITE;
  assign rd_en       = AVL_CS & AVL_READ;
  assign ctrl_wr     = wr_en & ctrl_sel;
  assign commit      = ctrl_wr & AVL_WRITEDATA[0];
  assign clr_overrun = ctrl_wr & AVL_WRITEDATA[1];
  // The consumer took a frame this cycle (even if a new commit refills it).
  assign consume     = EXPORT_ACK & pending_reg;

  // ---------------------------------------------------------------------------
  // Shadow bank: byte-enabled software writes
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int k = 0; k < NUM_CH; k++) begin
        shadow_reg[k] <= '0;
      end
    end else if (wr_en) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (ch_sel[k]) begin
          for (int b = 0; b < NUM_BYTES; b++) begin
            if (AVL_BYTE_EN[b]) begin
              shadow_reg[k][b*8 +: 8] <= AVL_WRITEDATA[b*8 +: 8];
            end
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Live bank: every channel copied on the same edge so the consumer never
  // observes a mix of two frames.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int k = 0; k < NUM_CH; k++) begin
        live_reg[k] <= '0;
      end
    end else if (commit) begin
      for (int k = 0; k < NUM_CH; k++) begin
        live_reg[k] <= shadow_reg[k];
      end
    end
  end

  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_export
      assign EXPORT_DATA[gi*DATA_W +: DATA_W] = live_reg[gi];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Handshake, overrun and frame counter
  // ---------------------------------------------------------------------------
  always_comb begin
    pending_next   = pending_reg;
    overrun_next   = overrun_reg;
    frame_cnt_next = frame_cnt_reg;

    if (commit) begin
      pending_next   = 1'b1;
      frame_cnt_next = frame_cnt_reg + 16'd1;
    end else if (consume) begin
      pending_next   = 1'b0;
    end

    // Overrun set has priority over a clear in the same CTRL write.
    if (commit && pending_reg && !EXPORT_ACK) begin
      overrun_next = 1'b1;
    end else if (clr_overrun) begin
      overrun_next = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pending_reg   <= 1'b0;
      overrun_reg   <= 1'b0;
      frame_cnt_reg <= 16'd0;
    end else begin
      pending_reg   <= pending_next;
      overrun_reg   <= overrun_next;
      frame_cnt_reg <= frame_cnt_next;
    end
  end

  assign EXPORT_NEW = pending_reg;
  assign FRAME_CNT  = frame_cnt_reg;

  // ---------------------------------------------------------------------------
  // Optional frame-consumed interrupt
  // ---------------------------------------------------------------------------
  logic irq_flag_bit;

`ifdef AVL_FRAME_IRQ_EN
  logic irq_en_reg;
  logic irq_en_next;
  logic irq_flag_reg;
  logic irq_flag_next;

  always_comb begin
    irq_en_next   = irq_en_reg;
    irq_flag_next = irq_flag_reg;
    if (ctrl_wr) begin
      irq_en_next = AVL_WRITEDATA[2];
    end
    // A consume in the same cycle as a clear leaves the flag set.
    if (consume) begin
      irq_flag_next = 1'b1;
    end else if (ctrl_wr && AVL_WRITEDATA[3]) begin
      irq_flag_next = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      irq_en_reg   <= 1'b0;
      irq_flag_reg <= 1'b0;
    end else begin
      irq_en_reg   <= irq_en_next;
      irq_flag_reg <= irq_flag_next;
    end
  end

  assign irq_flag_bit = irq_flag_reg;
  assign IRQ          = irq_flag_reg & irq_en_reg;
`else
  assign irq_flag_bit = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Read path: one-cycle registered read, holds between reads
  // ---------------------------------------------------------------------------
  logic [31:0]       status_word;
  logic [STAT_W-1:0] status_ext;

  assign status_word = {frame_cnt_reg, 13'd0, irq_flag_bit, overrun_reg, pending_reg};
  assign status_ext  = STAT_W'(status_word);

  always_comb begin
    readdata_next = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch_sel[k]) begin
        readdata_next = shadow_reg[k];
      end
    end
    if (status_sel) begin
      readdata_next = status_ext[DATA_W-1:0];
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      readdata_reg <= '0;
    end else if (rd_en) begin
      readdata_reg <= readdata_next;
    end
  end

  assign AVL_READDATA = readdata_reg;

endmodule

// File: tb/tb_avalon_frame_regs.sv
// Directed testbench for avalon_frame_regs (default parameters).
// Inputs change on the falling edge; outputs are sampled on the falling edge.

module tb_avalon_frame_regs;

  localparam int NUM_CH = 8;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;

  logic                     CLK = 1'b0;
  logic                     RESET;
  logic [ADDR_W-1:0]        AVL_ADDR;
  logic                     AVL_CS;
  logic                     AVL_READ;
  logic                     AVL_WRITE;
  logic [DATA_W/8-1:0]      AVL_BYTE_EN;
  logic [DATA_W-1:0]        AVL_WRITEDATA;
  logic [DATA_W-1:0]        AVL_READDATA;
  logic [NUM_CH*DATA_W-1:0] EXPORT_DATA;
  logic                     EXPORT_NEW;
  logic                     EXPORT_ACK;
  logic [15:0]              FRAME_CNT;
`ifdef AVL_FRAME_IRQ_EN
  logic                     IRQ;
`endif

  always #5 CLK = ~CLK;

  avalon_frame_regs #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .AVL_ADDR      (AVL_ADDR),
    .AVL_CS        (AVL_CS),
    .AVL_READ      (AVL_READ),
    .AVL_WRITE     (AVL_WRITE),
    .AVL_BYTE_EN   (AVL_BYTE_EN),
    .AVL_WRITEDATA (AVL_WRITEDATA),
    .AVL_READDATA  (AVL_READDATA),
    .EXPORT_DATA   (EXPORT_DATA),
    .EXPORT_NEW    (EXPORT_NEW),
    .EXPORT_ACK    (EXPORT_ACK),
    .FRAME_CNT     (FRAME_CNT)
`ifdef AVL_FRAME_IRQ_EN
    ,
    .IRQ           (IRQ)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic bus_write(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge CLK);
    AVL_ADDR = a; AVL_WRITEDATA = d; AVL_BYTE_EN = be;
    AVL_CS = 1'b1; AVL_WRITE = 1'b1;
    @(negedge CLK);
    AVL_CS = 1'b0; AVL_WRITE = 1'b0; AVL_BYTE_EN = '0;
  endtask

  task automatic bus_read(input logic [ADDR_W-1:0] a, output logic [31:0] d);
    @(negedge CLK);
    AVL_ADDR = a; AVL_CS = 1'b1; AVL_READ = 1'b1;
    @(negedge CLK);
    AVL_CS = 1'b0; AVL_READ = 1'b0;
    d = AVL_READDATA;
  endtask

  task automatic pulse_ack();
    @(negedge CLK);
    EXPORT_ACK = 1'b1;
    @(negedge CLK);
    EXPORT_ACK = 1'b0;
  endtask

  logic [31:0]  rd;
  logic [255:0] exp_live;
  logic [3:0]   a4;

  initial begin
    RESET = 1'b1; AVL_ADDR = '0; AVL_CS = 1'b0; AVL_READ = 1'b0; AVL_WRITE = 1'b0;
    AVL_BYTE_EN = '0; AVL_WRITEDATA = '0; EXPORT_ACK = 1'b0;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;

    // Reset state
    check("rst_readdata", AVL_READDATA, 0);
    check("rst_new", EXPORT_NEW, 0);
    check("rst_export", EXPORT_DATA, 0);
    check("rst_cnt", FRAME_CNT, 0);
    for (int i = 0; i < 16; i++) begin
      a4 = 4'(i);
      bus_read(a4, rd);
      check($sformatf("rst_rd_a%0d", i), rd, 0);
    end

    // Byte-enable write on ch2
    bus_write(4'd2, 32'hFFFF_FFFF, 4'hF);
    bus_write(4'd2, 32'hAABB_CCDD, 4'h5);
    bus_read(4'd2, rd);
    check("be_rd_ch2", rd, 32'hFFBB_FFDD);
    @(negedge CLK);
    check("rd_hold", AVL_READDATA, 32'hFFBB_FFDD);
    check("be_export_unch", EXPORT_DATA, 0);

    // Atomic commit of 8 channels
    exp_live = '0;
    for (int k = 0; k < 8; k++) begin
      a4 = 4'(k);
      bus_write(a4, 32'h100 + 32'(k), 4'hF);
      exp_live[k*32 +: 32] = 32'h100 + 32'(k);
    end
    check("pre_commit_export", EXPORT_DATA, 0);
    bus_write(4'd8, 32'h1, 4'hF);
    check("commit_export", EXPORT_DATA, exp_live);
    check("commit_new", EXPORT_NEW, 1);
    check("commit_cnt", FRAME_CNT, 1);
    bus_read(4'd9, rd);
    check("commit_status", rd, 32'h0001_0001);
    bus_read(4'd8, rd);
    check("ctrl_reads0", rd, 0);

    // Second commit without ack -> overrun, latest frame wins
    bus_write(4'd0, 32'h200, 4'hF);
    exp_live[31:0] = 32'h200;
    bus_write(4'd8, 32'h1, 4'hF);
    check("ovr_export", EXPORT_DATA, exp_live);
    bus_read(4'd9, rd);
    check("ovr_status", rd, 32'h0002_0003);
    pulse_ack();
    check("ack_new", EXPORT_NEW, 0);
    bus_read(4'd9, rd);
    check("ack_status", rd, 32'h0002_0002);
    bus_write(4'd8, 32'h2, 4'hF);
    bus_read(4'd9, rd);
    check("clr_ovr_status", rd, 32'h0002_0000);
    pulse_ack();
    check("idle_ack_new", EXPORT_NEW, 0);

    // Commit, then commit+ack in the same cycle
    bus_write(4'd8, 32'h1, 4'hF);
    @(negedge CLK);
    AVL_ADDR = 4'd8; AVL_WRITEDATA = 32'h1; AVL_BYTE_EN = 4'hF;
    AVL_CS = 1'b1; AVL_WRITE = 1'b1; EXPORT_ACK = 1'b1;
    @(negedge CLK);
    AVL_CS = 1'b0; AVL_WRITE = 1'b0; EXPORT_ACK = 1'b0;
    check("cack_new", EXPORT_NEW, 1);
    bus_read(4'd9, rd);
    check("cack_status", rd, 32'h0004_0001);

    // Clear and overrunning commit together: set wins
    bus_write(4'd8, 32'h3, 4'hF);
    bus_read(4'd9, rd);
    check("setwins_status", rd, 32'h0005_0003);
    check("setwins_export", EXPORT_DATA, exp_live);

    // Counter wrap: 65530 more commits reach 0xFFFF, one more wraps to 0
    @(negedge CLK);
    AVL_ADDR = 4'd8; AVL_WRITEDATA = 32'h1; AVL_BYTE_EN = 4'hF;
    AVL_CS = 1'b1; AVL_WRITE = 1'b1;
    repeat (65530) @(negedge CLK);
    check("cnt_ffff", FRAME_CNT, 16'hFFFF);
    @(negedge CLK);
    check("cnt_wrap", FRAME_CNT, 0);
    AVL_CS = 1'b0; AVL_WRITE = 1'b0;

    // Out-of-map accesses
    bus_write(4'd12, 32'hDEAD_BEEF, 4'hF);
    bus_read(4'd12, rd);
    check("oom_rd", rd, 0);
    check("oom_export", EXPORT_DATA, exp_live);

    // Reset mid-frame drops the pending handshake
    check("pre_rst_new", EXPORT_NEW, 1);
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    check("mid_rst_new", EXPORT_NEW, 0);
    check("mid_rst_export", EXPORT_DATA, 0);
    check("mid_rst_cnt", FRAME_CNT, 0);
    check("mid_rst_readdata", AVL_READDATA, 0);
    bus_read(4'd9, rd);
    check("mid_rst_status", rd, 0);
    bus_read(4'd2, rd);
    check("mid_rst_ch2", rd, 0);

`ifdef AVL_FRAME_IRQ_EN
    bus_write(4'd8, 32'h4, 4'hF);
    bus_write(4'd8, 32'h5, 4'hF);
    check("irq_before_ack", IRQ, 0);
    pulse_ack();
    check("irq_set", IRQ, 1);
    bus_read(4'd9, rd);
    check("irq_status", rd, 32'h0001_0004);
    bus_write(4'd8, 32'hC, 4'hF);
    check("irq_clr", IRQ, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
